uart_stream_tx: RTL and testbench

Parametrised buffered UART transmitter, successor to the single-byte serial TX path. Accepts words from an upstream source over a valid/ready handshake into an internal FIFO and serialises them back-to-back. Frame format is configurable: data width, parity mode, stop bits and bit period. An enable input pauses transmission at frame boundaries. Sits between a data source (message ROM, counter, host logic) and the board TX pin.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_stream_tx.sv | 141 ++++++++++++++
 tb/tb_uart_stream_tx.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmit path: parity modes, FSM
// states and the frame-length helper used by both RTL and bench.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    function automatic int frame_cycles(input int data_bits, input int parity,
                                        input int stop_bits, input int clks_per_bit);
        return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; one extra pointer bit lets the
// MSB difference distinguish full from empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_fire;
    logic             rd_fire;

    assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign level_o   = wr_ptr_q - rd_ptr_q;
    assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_fire = wr_en_i && !full_o;
    assign rd_fire = rd_en_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end

endmodule

// File: rtl/uart_stream_tx.sv
// Buffered UART transmitter: FIFO-fed, configurable frame format, frames sent
// back-to-back while enabled; enable is honoured only at frame boundaries.
module uart_stream_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    input  logic [DATA_BITS-1:0]          i_data,
    output logic                          o_ready,
    input  logic                          i_enable,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_uart_tx,
    output logic                          o_uart_clk
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = 4;
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic          PAR_INIT  = (PARITY == PAR_ODD);

    tx_state_e              state_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [BW-1:0]          bit_cnt_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_q;
    logic                   tx_q;
    logic                   busy_q;
    logic                   tick_q;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [DATA_BITS-1:0]   fifo_rd_data;
    logic                   bit_end;
    logic                   pop;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i     (i_clk),
        .rst_ni    (i_rst_n),
        .wr_en_i   (i_valid),
        .wr_data_i (i_data),
        .rd_en_i   (pop),
        .rd_data_o (fifo_rd_data),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (o_fifo_level)
    );

    assign o_ready    = !fifo_full;
    assign o_uart_tx  = tx_q;
    assign o_busy     = busy_q;
    assign o_uart_clk = tick_q;

    assign bit_end = (cnt_q == CNT_LAST);
    // A new frame may start from idle, or on the final stop cycle for a zero gap.
    assign pop = !fifo_empty && i_enable &&
                 ((state_q == ST_IDLE) ||
                  (state_q == ST_STOP && bit_end && bit_cnt_q == STOP_LAST));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (state_q == ST_IDLE || bit_end) cnt_d = '0;
    end

    // Line, busy and tick are registered from the current state, so all three
    // lag the FSM by one cycle and stay mutually aligned.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (state_q != ST_IDLE);
            tick_q <= (state_q != ST_IDLE) && (cnt_q == '0);
            case (state_q)
                ST_START:  tx_q <= 1'b0;
                ST_DATA:   tx_q <= shift_q[0];
                ST_PARITY: tx_q <= par_q;
                default:   tx_q <= 1'b1;
            endcase

            if (pop) begin
                state_q   <= ST_START;
                shift_q   <= fifo_rd_data;
                par_q     <= PAR_INIT;
                bit_cnt_q <= '0;
            end else begin
                case (state_q)
                    ST_START: begin
                        if (bit_end) state_q <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_end) begin
                            shift_q <= shift_q >> 1;
                            par_q   <= par_q ^ shift_q[0];
                            if (bit_cnt_q == DATA_LAST) begin
                                bit_cnt_q <= '0;
                                state_q   <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_end) state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        if (bit_end) begin
                            if (bit_cnt_q == STOP_LAST) begin
                                bit_cnt_q <= '0;
                                state_q   <= ST_IDLE;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_stream_tx.sv
// Scoreboard bench for uart_stream_tx: three instances cover even/none/odd
// parity; a line monitor decodes frames and checks them against queued words.
module tb_uart_stream_tx;

    localparam int CPB = 4;

    typedef struct {
        logic [7:0] data;
        logic       par;
    } expEntry_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] dataIn;
    logic       enable;
    logic       validA, validB, validC;
    logic       readyA, readyB, readyC;
    logic       busyA, busyB, busyC;
    logic       txA, txB, txC;
    logic       tickA, tickB, tickC;
    logic [2:0] levelA;
    logic [4:0] levelB;
    logic [2:0] levelC;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         monSel = 0;
    expEntry_t  expQ[$];
    int         startCyc[$];
    logic       monLine, monTick;

    // A: even parity, 2 stops, depth 4.  B: no parity, 1 stop, depth 16.  C: odd parity, 2 stops.
    uart_stream_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dutA (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(validA), .i_data(dataIn), .o_ready(readyA),
        .i_enable(enable), .o_busy(busyA), .o_fifo_level(levelA), .o_uart_tx(txA), .o_uart_clk(tickA));
    uart_stream_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(16)) dutB (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(validB), .i_data(dataIn), .o_ready(readyB),
        .i_enable(enable), .o_busy(busyB), .o_fifo_level(levelB), .o_uart_tx(txB), .o_uart_clk(tickB));
    uart_stream_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dutC (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(validC), .i_data(dataIn), .o_ready(readyC),
        .i_enable(enable), .o_busy(busyC), .o_fifo_level(levelC), .o_uart_tx(txC), .o_uart_clk(tickC));

    assign monLine = (monSel == 0) ? txA : (monSel == 1) ? txB : txC;
    assign monTick = (monSel == 0) ? tickA : (monSel == 1) ? tickB : tickC;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int parOf(input int sel);
        return (sel == 0) ? 2 : (sel == 1) ? 0 : 1;
    endfunction

    function automatic int stopsOf(input int sel);
        return (sel == 1) ? 1 : 2;
    endfunction

    function automatic logic readyOf(input int sel);
        return (sel == 0) ? readyA : (sel == 1) ? readyB : readyC;
    endfunction

    function automatic logic busyOf(input int sel);
        return (sel == 0) ? busyA : (sel == 1) ? busyB : busyC;
    endfunction

    function automatic logic txOf(input int sel);
        return (sel == 0) ? txA : (sel == 1) ? txB : txC;
    endfunction

    function automatic logic tickOf(input int sel);
        return (sel == 0) ? tickA : (sel == 1) ? tickB : tickC;
    endfunction

    function automatic int levelOf(input int sel);
        return (sel == 0) ? int'(levelA) : (sel == 1) ? int'(levelB) : int'(levelC);
    endfunction

    task automatic setValid(input int sel, input logic v);
        if (sel == 0) validA = v;
        else if (sel == 1) validB = v;
        else validC = v;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present a word and hold it until accepted; the expectation is queued on the accepting edge.
    task automatic applyStimulus(input int sel, input logic [7:0] d, input logic p);
        int n = 0;
        expEntry_t e;
        @(negedge clk);
        dataIn = d;
        setValid(sel, 1'b1);
        while (!readyOf(sel) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!readyOf(sel)) begin
            checks++;
            errors++;
            $display("[TB] FAIL writeTimeout: got ready=0 expected ready=1 for word %0h", d);
            setValid(sel, 1'b0);
        end else begin
            @(posedge clk);
            e.data = d;
            e.par  = p;
            expQ.push_back(e);
            #1;
            setValid(sel, 1'b0);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", expQ.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    // Single word into an idle, empty, enabled DUT: latency, busy length and tick count.
    task automatic checkFrameTiming(input int sel, input logic [7:0] d, input logic p,
                                    input int expLen, input int expBits);
        int n = 0;
        int pulses = 1;
        applyStimulus(sel, d, p);
        checkOutput("levelAfterWrite", levelOf(sel), 1);
        @(posedge clk); #1;
        checkOutput("levelAfterPop", levelOf(sel), 0);
        checkOutput("lineBeforeStart", txOf(sel), 1);
        @(posedge clk); #1;
        checkOutput("startBit", txOf(sel), 0);
        checkOutput("startTick", tickOf(sel), 1);
        checkOutput("busyRise", busyOf(sel), 1);
        do begin
            @(posedge clk); #1;
            n++;
            if (tickOf(sel)) pulses++;
        end while (busyOf(sel) && n < 1000);
        checkOutput("frameLen", n, expLen);
        checkOutput("bitTicks", pulses, expBits);
    endtask

    task automatic waitBusy(input int sel);
        int n = 0;
        while (!busyOf(sel) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("busySeen", busyOf(sel), 1);
    endtask

    // Monitor: decode one frame per falling start edge, sampling each bit mid-period.
    initial begin : monitor
        logic [15:0] got, want;
        int total, nb, clkErrs;
        bit aborted;
        expEntry_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && monLine === 1'b0) begin
                startCyc.push_back(cyc);
                total = uart_pkg::frame_cycles(8, parOf(monSel), stopsOf(monSel), CPB);
                nb = total / CPB;
                got = '0;
                clkErrs = 0;
                aborted = 0;
                for (int i = 0; i < total; i++) begin
                    if (i > 0) @(negedge clk);
                    if (rst_n !== 1'b1) begin
                        aborted = 1;
                        break;
                    end
                    if ((i % CPB) == CPB / 2) got[i / CPB] = monLine;
                    if (monTick !== ((i % CPB) == 0)) clkErrs++;
                end
                if (!aborted) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpectedFrame: got frame %0h expected no frame", got);
                    end else begin
                        e = expQ.pop_front();
                        want = '0;
                        for (int b = 0; b < nb; b++) want[b] = 1'b1;
                        want[0] = 1'b0;
                        for (int j = 0; j < 8; j++) want[1 + j] = e.data[j];
                        if (parOf(monSel) != 0) want[9] = e.par;
                        checkOutput("frameBits", got, want);
                        checkOutput("frameTicks", clkErrs, 0);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int bad;
        logic [7:0] w;
        expEntry_t e;
        validA = 1'b0; validB = 1'b0; validC = 1'b0;
        dataIn = '0;
        enable = 1'b1;
        rst_n  = 1'b1;
        #2 rst_n = 1'b0;
        #2;
        checkOutput("rstTx", txA, 1);
        checkOutput("rstBusy", busyA, 0);
        checkOutput("rstReady", readyA, 1);
        checkOutput("rstTick", tickA, 0);
        checkOutput("rstLevel", levelA, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] single word, no parity, 1 stop");
        monSel = 1;
        checkFrameTiming(1, 8'h55, 1'b0, 40, 10);
        drain();

        $display("[TB] odd parity");
        monSel = 2;
        applyStimulus(2, 8'h07, 1'b0);
        applyStimulus(2, 8'hA3, 1'b1);
        drain();

        $display("[TB] even parity, 2 stops");
        monSel = 0;
        checkFrameTiming(0, 8'h07, 1'b1, 48, 12);
        drain();

        $display("[TB] fill while disabled, then back-to-back");
        enable = 1'b0;
        applyStimulus(0, 8'h01, 1'b1);
        applyStimulus(0, 8'h02, 1'b1);
        applyStimulus(0, 8'h03, 1'b0);
        applyStimulus(0, 8'h04, 1'b1);
        @(negedge clk);
        dataIn = 8'h05;
        validA = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("fullReady", readyA, 0);
            checkOutput("fullLevel", levelA, 4);
        end
        startCyc.delete();
        enable = 1'b1;
        bad = 0;
        while (!readyA && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        checkOutput("readyAfterPop", readyA, 1);
        @(posedge clk);
        e.data = 8'h05;
        e.par  = 1'b0;
        expQ.push_back(e);
        #1 validA = 1'b0;
        drain();
        checkOutput("b2bFrames", startCyc.size(), 5);
        for (int i = 1; i < startCyc.size(); i++)
            checkOutput("b2bSpacing", startCyc[i] - startCyc[i-1], 48);

        $display("[TB] pause mid-frame");
        applyStimulus(0, 8'hA3, 1'b0);
        applyStimulus(0, 8'h11, 1'b0);
        applyStimulus(0, 8'h22, 1'b0);
        waitBusy(0);
        repeat (10) @(negedge clk);
        enable = 1'b0;
        bad = 0;
        while (busyA && bad < 200) begin
            @(negedge clk);
            bad++;
        end
        checkOutput("pauseBusy", busyA, 0);
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (txA !== 1'b1 || busyA !== 1'b0) bad++;
        end
        checkOutput("pauseIdleLine", bad, 0);
        checkOutput("pauseLevel", levelA, 2);
        checkOutput("pauseQueued", expQ.size(), 2);
        enable = 1'b1;
        drain();

        $display("[TB] simultaneous write and pop");
        enable = 1'b0;
        applyStimulus(0, 8'h3C, 1'b0);
        applyStimulus(0, 8'h81, 1'b0);
        @(negedge clk);
        checkOutput("simLevelBefore", levelA, 2);
        enable = 1'b1;
        dataIn = 8'h7E;
        validA = 1'b1;
        @(posedge clk);
        e.data = 8'h7E;
        e.par  = 1'b0;
        expQ.push_back(e);
        #1 validA = 1'b0;
        checkOutput("simLevelAfter", levelA, 2);
        drain();

        $display("[TB] random stream");
        for (int k = 0; k < 200; k++) begin
            w = 8'($urandom_range(0, 255));
            applyStimulus(0, w, ^w);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain();

        $display("[TB] reset mid-frame");
        applyStimulus(0, 8'h5A, 1'b0);
        applyStimulus(0, 8'h3C, 1'b0);
        applyStimulus(0, 8'h0F, 1'b0);
        waitBusy(0);
        repeat (12) @(negedge clk);
        #2 rst_n = 1'b0;
        expQ.delete();
        #1;
        checkOutput("midRstTx", txA, 1);
        checkOutput("midRstBusy", busyA, 0);
        checkOutput("midRstLevel", levelA, 0);
        checkOutput("midRstReady", readyA, 1);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 8'hC6, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
